// File: rtl/ms108_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU ops, FSM states,
// and datapath mux selects.
package ms108_pkg;

  localparam logic [3:0] ALU_LW    = 4'b0000;
  localparam logic [3:0] ALU_SW    = 4'b0001;
  localparam logic [3:0] ALU_LI    = 4'b0010;
  localparam logic [3:0] ALU_ADDU  = 4'b0011;
  localparam logic [3:0] ALU_ADDIU = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_J     = 4'b0110;
  localparam logic [3:0] ALU_BGE   = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_MULI  = 4'b1001;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_BGE = 3'b011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: turns the 4-bit opcode into instruction class flags and
// the ALU operation used during EXEC.
module ctrl_decode
  import ms108_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_mul,
  output logic       is_branch,
  output logic       is_jump,
  output logic       writes_reg,
  output logic       uses_imm,
  output logic       illegal,
  output logic [2:0] alu_op
);

  always_comb begin
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_mul     = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    writes_reg = 1'b0;
    uses_imm   = 1'b0;
    illegal    = 1'b0;
    alu_op     = OP_ADD;
    case (opcode)
      ALU_LW:    begin is_mem = 1'b1; writes_reg = 1'b1; uses_imm = 1'b1; end
      ALU_SW:    begin is_mem = 1'b1; is_store = 1'b1; uses_imm = 1'b1; end
      ALU_LI:    begin writes_reg = 1'b1; uses_imm = 1'b1; end
      ALU_ADDU:  begin writes_reg = 1'b1; end
      ALU_ADDIU: begin writes_reg = 1'b1; uses_imm = 1'b1; end
      ALU_SLL:   begin writes_reg = 1'b1; uses_imm = 1'b1; alu_op = OP_SLL; end
      ALU_J:     begin is_jump = 1'b1; uses_imm = 1'b1; end
      ALU_BGE:   begin is_branch = 1'b1; alu_op = OP_BGE; end
      ALU_MUL:   begin is_mul = 1'b1; writes_reg = 1'b1; alu_op = OP_MUL; end
      ALU_MULI:  begin is_mul = 1'b1; writes_reg = 1'b1; uses_imm = 1'b1; alu_op = OP_MUL; end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// multi-cycle multiply hold in EXEC and an absorbing TRAP for illegal opcodes.
module multicycle_ctrl
  import ms108_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] IR_i,
  input  logic        mem_ready_i,
  input  logic        bge_taken_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_src_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_src_o,
  output logic        reg_we_o,
  output logic        wb_sel_o,
  output logic [2:0]  state_o,
  output logic        illegal_o
);

  state_t     state, state_nxt;
  logic [3:0] mul_cnt;
  logic [3:0] opcode;
  logic       unused_ir;

  logic       is_mem, is_store, is_mul, is_branch, is_jump;
  logic       writes_reg, uses_imm, illegal;
  logic [2:0] alu_op;
  logic       exec_done;

  assign opcode    = IR_i[31:28];
  assign unused_ir = ^IR_i[27:0];

  ctrl_decode u_decode (
    .opcode     (opcode),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .is_mul     (is_mul),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .writes_reg (writes_reg),
    .uses_imm   (uses_imm),
    .illegal    (illegal),
    .alu_op     (alu_op)
  );

  assign exec_done = !is_mul || (mul_cnt == 4'(MUL_CYCLES - 1));

  // EXEC is only ever entered from DECODE, so clearing outside EXEC equals clearing on entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_FETCH;
      mul_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= (state == ST_EXEC) ? mul_cnt + 4'd1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (mem_ready_i) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
          if (is_mem)          state_nxt = ST_MEM;
          else if (writes_reg) state_nxt = ST_WB;
          else                 state_nxt = ST_FETCH;
        end
      end
      ST_MEM:    if (mem_ready_i) state_nxt = is_store ? ST_FETCH : ST_WB;
      ST_WB:     state_nxt = ST_FETCH;
      ST_TRAP:   state_nxt = ST_TRAP;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    ir_we_o   = 1'b0;
    pc_we_o   = 1'b0;
    pc_src_o  = PC_SRC_SEQ;
    alu_op_o  = OP_ADD;
    alu_src_o = 1'b0;
    reg_we_o  = 1'b0;
    wb_sel_o  = WB_SEL_ALU;
    illegal_o = 1'b0;
    state_o   = rst_i ? '0 : state;
    if (!rst_i) begin
      case (state)
        ST_FETCH: begin
          mem_req_o = 1'b1;
          ir_we_o   = mem_ready_i;
          pc_we_o   = mem_ready_i;
        end
        ST_EXEC: begin
          alu_op_o  = alu_op;
          alu_src_o = uses_imm;
          if (is_jump) begin
            pc_we_o  = 1'b1;
            pc_src_o = PC_SRC_JUMP;
          end else if (is_branch) begin
            pc_we_o  = bge_taken_i;
            pc_src_o = PC_SRC_BRANCH;
          end
        end
        ST_MEM: begin
          mem_req_o = 1'b1;
          mem_we_o  = is_store;
        end
        ST_WB: begin
          reg_we_o = 1'b1;
          wb_sel_o = (is_mem && !is_store) ? WB_SEL_MEM : WB_SEL_ALU;
        end
        ST_TRAP:  illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase-list model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_multicycle_ctrl;
  import ms108_pkg::*;

  localparam int unsigned MC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, ready = 1'b0, taken = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_req, mem_we, ir_we, pc_we, alu_src, reg_we, wb_sel, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op, state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk_i(clk), .rst_i(rst), .IR_i(ir), .mem_ready_i(ready), .bge_taken_i(taken),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .ir_we_o(ir_we), .pc_we_o(pc_we),
    .pc_src_o(pc_src), .alu_op_o(alu_op), .alu_src_o(alu_src), .reg_we_o(reg_we),
    .wb_sel_o(wb_sel), .state_o(state_o), .illegal_o(illegal)
  );

  int unsigned n_cmp = 0, n_bad = 0;
  int          q[$];          // remaining phases of the current instruction; empty = FETCH
  logic [31:0] next_ir = '0;
  logic [15:0] act_v, exp_v;

  // Output vector: {req,we,ir_we,pc_we,pc_src[2],alu_op[3],alu_src,reg_we,wb_sel,state[3],illegal}
  function automatic logic [15:0] expect_outs(input bit r, input int st, input logic [3:0] op,
                                              input bit rdy, input bit tk);
    logic req = 1'b0, we = 1'b0, irw = 1'b0, pcw = 1'b0, asrc = 1'b0, rw = 1'b0, wsel = 1'b0, ill = 1'b0;
    logic [1:0] src = 2'd0;
    logic [2:0] aop = 3'd0;
    if (!r) begin
      case (st)
        0: begin req = 1'b1; irw = rdy; pcw = rdy; end
        2: begin
          aop  = (op == ALU_MUL || op == ALU_MULI) ? 3'd1 :
                 (op == ALU_SLL) ? 3'd2 : (op == ALU_BGE) ? 3'd3 : 3'd0;
          asrc = !(op == ALU_ADDU || op == ALU_MUL || op == ALU_BGE);
          if (op == ALU_J)   begin pcw = 1'b1; src = 2'd2; end
          if (op == ALU_BGE) begin pcw = tk;   src = 2'd1; end
        end
        3: begin req = 1'b1; we = (op == ALU_SW); end
        4: begin rw = 1'b1; wsel = (op == ALU_LW); end
        7: ill = 1'b1;
        default: ;
      endcase
    end
    return {req, we, irw, pcw, src, aop, asrc, rw, wsel, r ? 3'd0 : 3'(st), ill};
  endfunction

  function automatic void build_queue(input logic [3:0] op);
    int n;
    q.push_back(1);
    if (op > 4'd9) begin
      q.push_back(7);
      return;
    end
    n = (op == ALU_MUL || op == ALU_MULI) ? int'(MC) : 1;
    for (int i = 0; i < n; i++) q.push_back(2);
    if (op == ALU_LW) begin q.push_back(3); q.push_back(4); end
    else if (op == ALU_SW) q.push_back(3);
    else if (op != ALU_J && op != ALU_BGE) q.push_back(4);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit rdy, input bit tk);
    int st;
    @(negedge clk);
    rst = r; ready = rdy; taken = tk;
    #1;
    st    = (q.size() == 0) ? 0 : q[0];
    exp_v = expect_outs(r, st, ir[31:28], rdy, tk);
    act_v = {mem_req, mem_we, ir_we, pc_we, pc_src, alu_op, alu_src, reg_we, wb_sel, state_o, illegal};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL outs: actual %h required %h (phase %0d op %h) at %0t", act_v, exp_v, st, ir[31:28], $time);
    end
    @(posedge clk);
    #1;
    if (r) q.delete();
    else if (q.size() == 0) begin
      if (rdy) begin
        ir = next_ir;
        build_queue(next_ir[31:28]);
      end
    end else if (q[0] == 7) ;
    else if (q[0] == 3 && !rdy) ;
    else void'(q.pop_front());
  endtask

  int n, trap_cnt;
  int addu_seq[5] = '{0, 1, 2, 4, 0};
  bit r, rdy;
  logic [3:0] op;

  initial begin
    cycle(1, 0, 0);
    check("reset_outs", int'(act_v), 0);

    // ADDU with ready tied high
    next_ir = 32'h3123_4567;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0);
      check("addu_state", int'(act_v[3:1]), addu_seq[i]);
      check("addu_reg_we", int'(act_v[5]), (addu_seq[i] == 4) ? 1 : 0);
      if (i == 2) check("addu_alu_op", int'(act_v[9:7]), 0);
    end

    // LW with three wait cycles in MEM
    cycle(1, 0, 0);
    next_ir = 32'h0000_0010;
    cycle(0, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, (i == 3), 0);
      if (act_v[3:1] == 3'd3 && act_v[15] && !act_v[14]) n++;
    end
    check("lw_mem_cycles", n, 4);
    cycle(0, 0, 0);
    check("lw_wb_state", int'(act_v[3:1]), 4);
    check("lw_wb_sel", int'(act_v[4]), 1);

    // BGE taken, then not taken
    cycle(1, 0, 0);
    next_ir = 32'h7000_0000;
    cycle(0, 1, 0); cycle(0, 0, 0); cycle(0, 0, 1);
    check("bge_t_pc_we", int'(act_v[12]), 1);
    check("bge_t_pc_src", int'(act_v[11:10]), 1);
    cycle(0, 1, 0);
    check("bge_t_next", int'(act_v[3:1]), 0);
    cycle(0, 0, 0); cycle(0, 0, 0);
    check("bge_nt_pc_we", int'(act_v[12]), 0);
    cycle(0, 0, 0);
    check("bge_nt_next", int'(act_v[3:1]), 0);

    // MULI holds EXEC for MUL_CYCLES
    cycle(1, 0, 0);
    next_ir = 32'h9000_0003;
    cycle(0, 1, 0); cycle(0, 0, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0);
      if (act_v[3:1] != 3'd2) break;
      if (act_v[9:7] == 3'd1 && act_v[6]) n++;
    end
    check("muli_exec_cycles", n, 4);
    check("muli_then_wb", int'(act_v[3:1]), 4);

    // Illegal opcode traps until reset
    cycle(1, 0, 0);
    next_ir = 32'hC000_0000;
    cycle(0, 1, 0); cycle(0, 1, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1);
      if (act_v[0] && act_v[3:1] == 3'd7 && !act_v[15]) n++;
    end
    check("trap_persist", n, 20);
    cycle(1, 0, 0);
    check("trap_rst_outs", int'(act_v), 0);
    cycle(0, 0, 0);
    check("trap_exit_state", int'(act_v[3:1]), 0);
    check("trap_exit_ill", int'(act_v[0]), 0);

    // Reset during SW MEM wait
    cycle(1, 0, 0);
    next_ir = 32'h1000_0004;
    cycle(0, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    check("sw_mem_we", int'(act_v[14]), 1);
    cycle(1, 1, 0);
    check("sw_rst_outs0", int'(act_v), 0);
    cycle(1, 0, 0);
    check("sw_rst_outs1", int'(act_v), 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      if (act_v[14]) n++;
    end
    check("sw_no_write_after_rst", n, 0);
    check("sw_first_req", int'(act_v[15]), 1);

    // Randomized traffic with occasional resets and illegal opcodes
    trap_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(10, 15));
      else                           op = 4'($urandom_range(0, 9));
      next_ir  = {op, 28'($urandom)};
      trap_cnt = (q.size() != 0 && q[0] == 7) ? trap_cnt + 1 : 0;
      r   = ($urandom_range(0, 59) == 0) || (trap_cnt > 25);
      rdy = ($urandom_range(0, 2) != 0);
      cycle(r, rdy, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
